// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared states, command codes and init table for the RTC bus machines
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_LOW  = 3'd1,
    ADDR_HIGH = 3'd2,
    DATA_LOW  = 3'd3,
    DATA_HIGH = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [3:0] CMD_INIT  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;

  localparam logic [7:0] WR_BASE  = 8'h21;
  localparam int         INIT_LEN = 2;

  // Entry 0 sits in the upper byte so the tables read in transfer order.
  localparam logic [15:0] INIT_ADDR = {8'h02, 8'h10};
  localparam logic [15:0] INIT_DATA = {8'h10, 8'hD2};

  function automatic logic [7:0] init_byte(input logic [15:0] tbl, input logic [2:0] idx);
    return (idx == 3'd0) ? tbl[15:8] : tbl[7:0];
  endfunction

endpackage

// File: rtl/contador_fase.sv
// rtl/contador_fase.sv - phase-length counter: clears on phase change, flags the last cycle
module contador_fase (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] limit,
  output logic       done
);

  logic [3:0] count;

  // Holds at the last count so a stalled phase never wraps back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (!done)
      count <= count + 4'd1;
  end

  assign done = (count == limit - 4'd1);

endmodule

// File: rtl/maquina_escritura.sv
// rtl/maquina_escritura.sv - RTC write-sequence machine (init table or time/date registers)
module maquina_escritura
  import rtc_bus_pkg::*;
#(
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 4,
  parameter int N_WR    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ctrl_G,
  input  logic [7:0] reg_data,
  output logic [2:0] reg_idx,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       Fin_I,
  output logic       Fin_W
);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic       mode_wr, mode_wr_n;
  logic       ph_done, ph_clear;
  logic [3:0] ph_limit;
  logic [2:0] len_m1;
  logic [3:0] cur_code;
  logic [7:0] addr_n, data_byte;

  assign ph_limit  = (state == ADDR_LOW || state == DATA_LOW) ? 4'(T_PULSE) : 4'(T_GAP);
  assign ph_clear  = (state_n != state);
  assign len_m1    = mode_wr ? 3'(N_WR - 1) : 3'(INIT_LEN - 1);
  assign cur_code  = mode_wr ? CMD_WRITE : CMD_INIT;
  assign addr_n    = mode_wr_n ? WR_BASE + {5'd0, idx_n} : init_byte(INIT_ADDR, idx_n);
  assign data_byte = mode_wr ? reg_data : init_byte(INIT_DATA, idx);

  contador_fase u_fase (
    .clk   (clk),
    .reset (reset),
    .clear (ph_clear),
    .limit (ph_limit),
    .done  (ph_done)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    mode_wr_n = mode_wr;
    case (state)
      IDLE: begin
        if (ctrl_G == CMD_INIT) begin
          mode_wr_n = 1'b0;
          idx_n     = '0;
          state_n   = ADDR_LOW;
        end else if (ctrl_G == CMD_WRITE) begin
          mode_wr_n = 1'b1;
          idx_n     = '0;
          state_n   = ADDR_LOW;
        end
      end
      ADDR_LOW:  if (ph_done) state_n = ADDR_HIGH;
      ADDR_HIGH: if (ph_done) state_n = DATA_LOW;
      DATA_LOW:  if (ph_done) state_n = DATA_HIGH;
      DATA_HIGH: if (ph_done) state_n = NEXT;
      NEXT: begin
        if (ctrl_G != cur_code)
          state_n = IDLE;
        else if (idx == len_m1)
          state_n = DONE;
        else begin
          idx_n   = idx + 3'd1;
          state_n = ADDR_LOW;
        end
      end
      DONE:    if (ctrl_G != cur_code) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      mode_wr <= 1'b0;
      reg_idx <= '0;
      CS_n    <= 1'b1;
      RD_n    <= 1'b1;
      WR_n    <= 1'b1;
      A_D     <= 1'b1;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      Fin_I   <= 1'b0;
      Fin_W   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      mode_wr <= mode_wr_n;
      reg_idx <= idx_n;
      RD_n    <= 1'b1;
      Fin_I   <= (state_n == DONE) && (state != DONE) && !mode_wr;
      Fin_W   <= (state_n == DONE) && (state != DONE) && mode_wr;
      case (state_n)
        ADDR_LOW: begin
          CS_n    <= 1'b0;
          WR_n    <= 1'b0;
          A_D     <= 1'b0;
          bus_oe  <= 1'b1;
          bus_out <= addr_n;
        end
        ADDR_HIGH: WR_n <= 1'b1;
        DATA_LOW: begin
          // Entered only from the last ADDR_HIGH cycle: this is where the data byte is latched.
          CS_n    <= 1'b0;
          WR_n    <= 1'b0;
          A_D     <= 1'b1;
          bus_out <= data_byte;
        end
        DATA_HIGH: begin
          CS_n <= 1'b1;
          WR_n <= 1'b1;
        end
        default: begin
          CS_n   <= 1'b1;
          WR_n   <= 1'b1;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_escritura.sv
// tb/tb_maquina_escritura.sv - randomized self-checking bench for maquina_escritura
module tb_maquina_escritura;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ctrl_G;
  logic [7:0] reg_data, reg_data_f;
  logic [2:0] reg_idx, reg_idx_f;
  logic       CS_n, RD_n, WR_n, A_D, bus_oe, Fin_I, Fin_W;
  logic       CS_n_f, RD_n_f, WR_n_f, A_D_f, bus_oe_f, Fin_I_f, Fin_W_f;
  logic [7:0] bus_out, bus_out_f;

  logic [7:0] tbl [8];
  bit         sel_fast;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [17:0] obs;

  always #5 clk = ~clk;

  assign reg_data   = tbl[reg_idx];
  assign reg_data_f = tbl[reg_idx_f];

  assign obs = sel_fast ?
    {CS_n_f, RD_n_f, WR_n_f, A_D_f, bus_oe_f, Fin_I_f, Fin_W_f, reg_idx_f, bus_out_f} :
    {CS_n, RD_n, WR_n, A_D, bus_oe, Fin_I, Fin_W, reg_idx, bus_out};

  maquina_escritura dut (
    .clk(clk), .reset(reset), .ctrl_G(ctrl_G), .reg_data(reg_data), .reg_idx(reg_idx),
    .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A_D(A_D), .bus_out(bus_out),
    .bus_oe(bus_oe), .Fin_I(Fin_I), .Fin_W(Fin_W)
  );

  maquina_escritura #(.T_PULSE(1), .T_GAP(2), .N_WR(6)) dut_fast (
    .clk(clk), .reset(reset), .ctrl_G(ctrl_G), .reg_data(reg_data_f), .reg_idx(reg_idx_f),
    .CS_n(CS_n_f), .RD_n(RD_n_f), .WR_n(WR_n_f), .A_D(A_D_f), .bus_out(bus_out_f),
    .bus_oe(bus_oe_f), .Fin_I(Fin_I_f), .Fin_W(Fin_W_f)
  );

  // Expected pins in cycle c after the start edge, from the transfer/phase arithmetic.
  function automatic logic [17:0] model(input int c, input bit wr, input int tp, input int tg,
                                        input int len, input int abort_t);
    int P, end_c, t, o;
    bit cs, wrn, ad, oe, fi, fw;
    logic [7:0] a, d, b;
    P     = 2 * tp + 2 * tg + 1;
    end_c = (abort_t >= 0) ? (abort_t + 1) * P : len * P;
    fi = 1'b0;
    fw = 1'b0;
    if (c <= end_c) begin
      t = (c - 1) / P;
      o = (c - 1) % P;
    end else begin
      t = (abort_t >= 0) ? abort_t : len - 1;
      o = P - 1;
      if (abort_t < 0 && c == end_c + 1) begin
        fi = !wr;
        fw = wr;
      end
    end
    a = wr ? 8'h21 + 8'(t) : ((t == 0) ? 8'h02 : 8'h10);
    d = wr ? tbl[t] : ((t == 0) ? 8'h10 : 8'hD2);
    if (o < tp) begin
      cs = 0; wrn = 0; ad = 0; oe = 1; b = a;
    end else if (o < tp + tg) begin
      cs = 0; wrn = 1; ad = 0; oe = 1; b = a;
    end else if (o < 2 * tp + tg) begin
      cs = 0; wrn = 0; ad = 1; oe = 1; b = d;
    end else if (o < 2 * tp + 2 * tg) begin
      cs = 1; wrn = 1; ad = 1; oe = 1; b = d;
    end else begin
      cs = 1; wrn = 1; ad = 1; oe = 0; b = d;
    end
    return {cs, 1'b1, wrn, ad, oe, fi, fw, 3'(t), b};
  endfunction

  task automatic check(input string tag, input int c, input logic [17:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic run_seq(input string tag, input bit wr, input bit fast, input int abort_t,
                         input int hold, input int reset_c);
    int tp, tg, len, P, end_c, last, abort_c;
    tp      = fast ? 1 : 4;
    tg      = fast ? 2 : 4;
    len     = wr ? 6 : 2;
    P       = 2 * tp + 2 * tg + 1;
    end_c   = (abort_t >= 0) ? (abort_t + 1) * P : len * P;
    last    = end_c + 1 + hold;
    abort_c = (abort_t >= 0) ? abort_t * P + int'($urandom_range(1, P)) : -1;
    sel_fast = fast;
    @(negedge clk);
    ctrl_G = wr ? 4'b0100 : 4'b0010;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check(tag, c, model(c, wr, tp, tg, len, abort_t));
      if (c == abort_c) ctrl_G = 4'b0000;
      if (c == reset_c) begin
        reset  = 1'b0;
        ctrl_G = 4'b0000;
        #1;
        check("reset_mid_data", c, 18'b1111_000_000_00000000);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
    ctrl_G = 4'b0000;
    for (int c = last + 1; c <= last + 3; c++) begin
      @(negedge clk);
      check({tag, "_release"}, c, model(c, wr, tp, tg, len, abort_t));
    end
  endtask

  task automatic shuffle_tbl();
    for (int i = 0; i < 8; i++) tbl[i] = 8'($urandom);
  endtask

  initial begin
    int t;
    reset    = 1'b0;
    ctrl_G   = 4'b0000;
    sel_fast = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = 8'h30 + 8'(i);
    repeat (2) @(negedge clk);
    check("reset_state", 0, 18'b1111_000_000_00000000);
    reset = 1'b1;
    @(negedge clk);

    run_seq("init", 1'b0, 1'b0, -1, 3, -1);
    run_seq("write_hold", 1'b1, 1'b0, -1, 20, -1);

    shuffle_tbl();
    run_seq("write_abort", 1'b1, 1'b0, 2, 10, -1);

    shuffle_tbl();
    t = int'($urandom_range(0, 5));
    run_seq("write_reset", 1'b1, 1'b0, -1, 0, t * 17 + 8 + int'($urandom_range(1, 4)));
    shuffle_tbl();
    run_seq("write_restart", 1'b1, 1'b0, -1, 5, -1);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    shuffle_tbl();
    run_seq("fast_write", 1'b1, 1'b1, -1, 5, -1);
    run_seq("fast_init", 1'b0, 1'b1, -1, 3, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
